instr_fetch_ctrl: RTL and testbench

Instruction fetch controller for the RV32I core. It owns the program counter and drives the byte address into the combinational-read instruction memory. Fetched instruction/PC pairs go into a 2-entry buffer, which feeds decode through a valid/ready handshake. The block also handles control-flow redirects from execute and flags fetch faults (misaligned or out-of-range PC) instead of issuing them.

---
 rtl/instr_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads a combinational instruction
// memory and queues {pc, instr} pairs in a 2-entry FIFO toward decode.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        fault_q, fault_nxt;
    logic [31:0] fault_pc_q, fault_pc_nxt;

    logic [1:0]  count;
    logic [31:0] head_pc, head_instr;
    logic [31:0] tail_pc, tail_instr;

    logic        deq;
    logic        enq;
    logic        legal;
    logic        space;

    assign deq   = (count != 2'd0) && out_ready;
    assign legal = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
    assign space = (count != 2'd2) || deq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            fault_q    <= fault_nxt;
            fault_pc_q <= fault_pc_nxt;
        end
    end

    // Redirect outranks everything; in FAULT the PC is parked until redirected.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        fault_nxt    = fault_q;
        fault_pc_nxt = fault_pc_q;
        enq          = 1'b0;
        if (redirect_valid) begin
            pc_nxt    = redirect_pc;
            state_nxt = RUN;
            fault_nxt = 1'b0;
        end else if (state == RUN && fetch_en) begin
            if (!legal) begin
                fault_nxt    = 1'b1;
                fault_pc_nxt = pc;
                state_nxt    = FAULT;
            end else if (space) begin
                enq    = 1'b1;
                pc_nxt = pc + 32'd4;
            end
        end
    end

    // Shift-style FIFO: head is always entry 0, so outputs come straight from registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            head_pc    <= 32'h0;
            head_instr <= 32'h0;
            tail_pc    <= 32'h0;
            tail_instr <= 32'h0;
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= pc;
                        head_instr <= imem_instr;
                    end else begin
                        tail_pc    <= pc;
                        tail_instr <= imem_instr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc    <= pc;
                        head_instr <= imem_instr;
                    end else begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= pc;
                        tail_instr <= imem_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_pc   = pc;
    assign out_valid = (count != 2'd0);
    assign out_pc    = head_pc;
    assign out_instr = head_instr;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; instruction memory returns a tag plus the word index.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        fault;
    logic [31:0] fault_pc;

    int errors = 0;
    int checks = 0;

    instr_fetch_ctrl #(.RESET_PC(32'h0), .MEM_SIZE(1024)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_pc(imem_pc),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_ready(out_ready), .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    assign imem_instr = {16'hC0DE, imem_pc[17:2]};

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'hC0DE, a[17:2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", imem_pc, 32'h0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL reset_head got %h/%h want 0/0", out_pc, out_instr); end
        checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault got %b/%h want 0/0", fault, fault_pc); end
    endtask

    task automatic test_straight_line();
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL straight_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("FAIL straight_pc[%0d] got %h want %h", i, out_pc, 32'(4 * i)); end
            checks++; if (out_instr !== word_at(32'(4 * i))) begin errors++; $display("FAIL straight_instr[%0d] got %h want %h", i, out_instr, word_at(32'(4 * i))); end
        end
        fetch_en = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h20) begin errors++; $display("FAIL drain got valid=%b pc=%h want 0/00000020", out_valid, imem_pc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        redirect_valid = 1'b1; redirect_pc = 32'h0; fetch_en = 1'b1; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h0) begin errors++; $display("FAIL bp_restart got valid=%b pc=%h want 0/0", out_valid, imem_pc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_hold[%0d] got valid=%b pc=%h want 1/0", i, out_valid, out_pc); end
        end
        checks++; if (imem_pc !== 32'h8) begin errors++; $display("FAIL bp_pc_stall got %h want 00000008", imem_pc); end
        out_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_pc !== exp_pc || out_instr !== word_at(exp_pc)) begin errors++; $display("FAIL bp_order[%0d] got %h/%h want %h/%h", i, out_pc, out_instr, exp_pc, word_at(exp_pc)); end
            if (i < 3) tick();
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        tick();
        checks++; if (imem_pc !== 32'h14 || out_pc !== 32'hC) begin errors++; $display("FAIL rf_full got pc=%h head=%h want 00000014/0000000c", imem_pc, out_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h40) begin errors++; $display("FAIL rf_flush got valid=%b pc=%h want 0/00000040", out_valid, imem_pc); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== word_at(32'h40)) begin errors++; $display("FAIL rf_target got %b/%h/%h want 1/00000040/%h", out_valid, out_pc, out_instr, word_at(32'h40)); end
    endtask

    task automatic test_out_of_range();
        out_ready = 1'b1; fetch_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'd1016;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd1016) begin errors++; $display("FAIL oor_first got %b/%h want 1/%h", out_valid, out_pc, 32'd1016); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd1020) begin errors++; $display("FAIL oor_second got %b/%h want 1/%h", out_valid, out_pc, 32'd1020); end
        tick();
        checks++; if (fault !== 1'b1 || fault_pc !== 32'd1024) begin errors++; $display("FAIL oor_fault got %b/%h want 1/%h", fault, fault_pc, 32'd1024); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL oor_noenq got %b want 0", out_valid); end
        tick(); tick();
        checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || imem_pc !== 32'd1024) begin errors++; $display("FAIL oor_sticky got %b/%b/%h want 1/0/%h", fault, out_valid, imem_pc, 32'd1024); end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b0 || fault_pc !== 32'd1024 || imem_pc !== 32'h0) begin errors++; $display("FAIL oor_clear got %b/%h/%h want 0/%h/0", fault, fault_pc, imem_pc, 32'd1024); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL oor_resume got %b/%h want 1/0", out_valid, out_pc); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL mis_redir got %b/%b want 0/0", out_valid, fault); end
        tick();
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h22) begin errors++; $display("FAIL mis_fault got %b/%h want 1/00000022", fault, fault_pc); end
        checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h22) begin errors++; $display("FAIL mis_noenq got %b/%h want 0/00000022", out_valid, imem_pc); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; fetch_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h28;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        checks++; if (imem_pc !== 32'h30 || out_pc !== 32'h28 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_setup got %h/%h/%b want 00000030/00000028/1", imem_pc, out_pc, out_valid); end
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h0) begin errors++; $display("FAIL rm_reset got %b/%h want 0/0", out_valid, imem_pc); end
        checks++; if (fault_pc !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL rm_values got %h/%h want 0/0", fault_pc, out_pc); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== word_at(32'h0)) begin errors++; $display("FAIL rm_restart got %b/%h/%h want 1/0/%h", out_valid, out_pc, out_instr, word_at(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect_full();
        test_out_of_range();
        test_misaligned();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
